queue_child_expander: RTL

- Downstream consumer of the popped minimum-cost queue entry in the FPGA pathfinding engine.
- Walks the six child slots of the expanded node and computes each tentative cost.
- For each child, drives the child-lookup stage through its find/done handshake.
- Inserts new children into the queue RAM, or overwrites existing entries when the new cost is lower (edge relaxation).

---
 rtl/queue_child_expander.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/queue_child_expander.sv
// Child expander: walks six child slots, looks each up and inserts/relaxes queue entries.
// Optional EXPANDER_STATS_EN adds saturating insert/update/skip counters.
module queue_child_expander #(
  parameter int ADDR_W      = 7,
  parameter int QUEUE_DEPTH = 128,
  parameter int NODE_W      = 272
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              expand,
  input  logic [NODE_W-1:0] parent_node,
  input  logic              tail_load,
  input  logic [ADDR_W:0]   tail_value,
  output logic              find_child,
  output logic [15:0]       child_id,
  input  logic              child_done,
  input  logic              child_queued,
  input  logic [ADDR_W-1:0] child_address,
  input  logic [15:0]       child_cost,
  output logic [15:0]       map_read_id,
  input  logic [NODE_W-1:0] map_read_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [NODE_W-1:0] write_data,
  output logic [ADDR_W:0]   tail,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef EXPANDER_STATS_EN
  ,
  output logic [15:0]       stat_inserts,
  output logic [15:0]       stat_updates,
  output logic [15:0]       stat_skips
`endif
);

  typedef enum logic [3:0] {
    IDLE, SEL, FIND, WAIT, DECIDE, MAP, WRITE, ADV, FIN
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(QUEUE_DEPTH);

  state_t            r_state;
  logic [2:0]        r_k;
  logic [15:0]       r_nid;
  logic [15:0]       r_pcost;
  logic [191:0]      r_kids;
  logic [15:0]       r_ncost;
  logic              r_queued;
  logic [ADDR_W-1:0] r_caddr;
  logic [15:0]       r_ccost;
  logic [ADDR_W-1:0] r_target;
  logic              r_insert;

  logic [15:0] w_ids   [6];
  logic [15:0] w_dists [6];
  for (genvar g = 0; g < 6; g++) begin : g_fld
    assign w_ids[g]   = r_kids[191-32*g -: 16];
    assign w_dists[g] = r_kids[175-32*g -: 16];
  end

  logic [15:0] w_id;
  logic [16:0] w_sum;
  logic [15:0] w_ncost;
  assign w_id    = w_ids[r_k];
  assign w_sum   = {1'b0, r_pcost} + {1'b0, w_dists[r_k]};
  assign w_ncost = w_sum[16] ? 16'hFFFF : w_sum[15:0];

  logic w_full, w_upd, w_ins;
  assign w_full = (tail >= DEPTH);
  assign w_upd  = r_queued && (r_ncost < r_ccost);
  assign w_ins  = !r_queued && !w_full;

  // ROM data arrives in WRITE, so the merge is combinational on it
  logic [NODE_W-1:0] w_wdata;
  assign w_wdata = {map_read_data[NODE_W-1:240], r_child_id_q(), r_nid,
                    r_ncost, map_read_data[191:0]};
  assign write_data = write_enable ? w_wdata : '0;

  function automatic logic [15:0] r_child_id_q();
    return child_id;
  endfunction

  logic w_unused;
  assign w_unused = ^{parent_node[NODE_W-1:240], parent_node[223:208],
                      map_read_data[239:192]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_k           <= '0;
      r_nid         <= '0;
      r_pcost       <= '0;
      r_kids        <= '0;
      r_ncost       <= '0;
      r_queued      <= 1'b0;
      r_caddr       <= '0;
      r_ccost       <= '0;
      r_target      <= '0;
      r_insert      <= 1'b0;
      find_child    <= 1'b0;
      child_id      <= '0;
      map_read_id   <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      tail          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      find_child    <= 1'b0;
      map_read_id   <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      done          <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (tail_load)
            tail <= (tail_value > DEPTH) ? DEPTH : tail_value;
          if (expand) begin
            r_nid   <= parent_node[239:224];
            r_pcost <= parent_node[207:192];
            r_kids  <= parent_node[191:0];
            r_k     <= '0;
            busy    <= 1'b1;
            r_state <= SEL;
          end
        end
        SEL: begin
          if (w_id == 16'd0) begin
            r_state <= ADV;
          end else begin
            r_ncost    <= w_ncost;
            child_id   <= w_id;
            find_child <= 1'b1;
            r_state    <= FIND;
          end
        end
        FIND: r_state <= WAIT;
        WAIT: begin
          if (child_done) begin
            r_queued <= child_queued;
            r_caddr  <= child_address;
            r_ccost  <= child_cost;
            r_state  <= DECIDE;
          end
        end
        DECIDE: begin
          if (w_upd || w_ins) begin
            r_target    <= w_upd ? r_caddr : tail[ADDR_W-1:0];
            r_insert    <= w_ins;
            map_read_id <= child_id;
            r_state     <= MAP;
          end else begin
            if (!r_queued) overflow <= 1'b1;
            r_state <= ADV;
          end
        end
        MAP: begin
          write_enable  <= 1'b1;
          write_address <= r_target;
          r_state       <= WRITE;
        end
        WRITE: begin
          if (r_insert) tail <= tail + (ADDR_W+1)'(1);
          r_state <= ADV;
        end
        ADV: begin
          if (r_k == 3'd5) begin
            done    <= 1'b1;
            r_state <= FIN;
          end else begin
            r_k     <= r_k + 3'd1;
            r_state <= SEL;
          end
        end
        FIN: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef EXPANDER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || (r_state == IDLE && tail_load)) begin
      stat_inserts <= '0;
      stat_updates <= '0;
      stat_skips   <= '0;
    end else if (r_state == DECIDE) begin
      if (w_ins)      stat_inserts <= sat_inc(stat_inserts);
      else if (w_upd) stat_updates <= sat_inc(stat_updates);
      else            stat_skips   <= sat_inc(stat_skips);
    end
  end
`endif

endmodule
